// File: rtl/lcd_rx_monitor.sv
// Receive-side monitor for a parallel RGB LCD stream: geometry checks, lock, frame checksum, probe pixel.
// Latency: inputs pass 2 register stages; frame results and frame_done appear 2 clocks after v_sync is sampled.
// Backpressure: none; the video stream is free-running and every pixel clock is consumed.
module lcd_rx_monitor #(
  parameter int H_ACTIVE        = 480,
  parameter int V_ACTIVE        = 272,
  parameter int SYNC_ACTIVE_LOW = 1,
  parameter int LOCK_FRAMES     = 3
) (
  input  logic        clk_in,
  input  logic        rst,
  input  logic [7:0]  r,
  input  logic [7:0]  g,
  input  logic [7:0]  b,
  input  logic        h_sync,
  input  logic        v_sync,
  input  logic        de,
  input  logic [10:0] probe_x,
  input  logic [9:0]  probe_y,
  output logic        frame_done,
  output logic [10:0] meas_h_total,
  output logic [9:0]  meas_v_total,
  output logic [9:0]  meas_v_active,
  output logic [23:0] frame_sum,
  output logic        frame_err,
  output logic        locked,
  output logic [23:0] probe_rgb,
  output logic        probe_hit
);

  // Pin level of a deasserted sync; sync stages reset to it so reset release never looks like an edge.
  localparam logic        SYNC_IDLE = (SYNC_ACTIVE_LOW != 0);
  localparam logic [10:0] H_ACT     = 11'(H_ACTIVE);
  localparam logic [9:0]  V_ACT     = 10'(V_ACTIVE);
  localparam logic [7:0]  LOCK_CNT  = 8'(LOCK_FRAMES);
  localparam logic [10:0] CYC_MAX   = 11'h7FF;
  localparam logic [9:0]  LINE_MAX  = 10'h3FF;

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2
  } state_t;

  state_t state;

  // Input pipeline: stage 1 holds the current sample, stage 2 the previous one.
  logic [23:0] pix1;
  logic        hs1, hs2, vs1, vs2, de1, de2;

  // Sync levels normalised to active-high, and the edges we act on.
  logic hs_on1, hs_on2, vs_on1, vs_on2;
  logic hs_ast, vs_ast, de_rise, de_fall;

  // Line and frame accumulation state.
  logic [10:0] cyc_cnt;
  logic [10:0] line_total;
  logic        have_total;
  logic [9:0]  line_cnt;
  logic [9:0]  act_cnt;
  logic        line_act;
  logic [10:0] x_cnt;
  logic        h_err;
  logic [23:0] sum_acc;
  logic        probe_done;
  logic [7:0]  good_cnt;

  // Closing-frame snapshot, taken on the v_sync edge and published one clock later.
  logic        close_pend;
  logic [10:0] snap_h_total;
  logic [9:0]  snap_v_total;
  logic [9:0]  snap_v_active;
  logic [23:0] snap_sum;
  logic        snap_err;

  // Next-state values after this cycle's line boundary has been applied.
  logic [10:0] x_base, nxt_x, nxt_cyc, nxt_total;
  logic        nxt_have, line_act_base, nxt_line_act, nxt_h_err;
  logic [9:0]  nxt_line_cnt, nxt_act, act_close;
  logic [23:0] nxt_sum;
  logic        probe_match;
  logic [7:0]  good_inc;

  assign hs_on1  = hs1 ^ SYNC_IDLE;
  assign hs_on2  = hs2 ^ SYNC_IDLE;
  assign vs_on1  = vs1 ^ SYNC_IDLE;
  assign vs_on2  = vs2 ^ SYNC_IDLE;
  assign hs_ast  = hs_on1 & ~hs_on2;
  assign vs_ast  = vs_on1 & ~vs_on2;
  assign de_rise = de1 & ~de2;
  assign de_fall = ~de1 & de2;

  // Register all inputs, then delay the control signals once more for edge detection.
  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      pix1 <= '0;
      hs1  <= SYNC_IDLE;
      hs2  <= SYNC_IDLE;
      vs1  <= SYNC_IDLE;
      vs2  <= SYNC_IDLE;
      de1  <= 1'b0;
      de2  <= 1'b0;
    end else begin
      pix1 <= {r, g, b};
      hs1  <= h_sync;
      hs2  <= hs1;
      vs1  <= v_sync;
      vs2  <= vs1;
      de1  <= de;
      de2  <= de1;
    end
  end

  // Per-cycle line bookkeeping; the h_sync boundary is folded in before any frame decision.
  always_comb begin
    x_base        = hs_ast ? 11'd0 : x_cnt;
    nxt_x         = x_base;
    if (de1 && (x_base != CYC_MAX)) begin
      nxt_x = x_base + 11'd1;
    end

    nxt_cyc       = cyc_cnt;
    if (hs_ast) begin
      nxt_cyc = 11'd1;
    end else if (cyc_cnt != CYC_MAX) begin
      nxt_cyc = cyc_cnt + 11'd1;
    end

    nxt_total     = hs_ast ? cyc_cnt : line_total;
    nxt_have      = have_total | hs_ast;

    nxt_line_cnt  = line_cnt;
    if (hs_ast && (line_cnt != LINE_MAX)) begin
      nxt_line_cnt = line_cnt + 10'd1;
    end

    // A line is counted as active when it closes, so act_cnt is the row index while it is drawn.
    nxt_act       = act_cnt;
    if (hs_ast && line_act && (act_cnt != LINE_MAX)) begin
      nxt_act = act_cnt + 10'd1;
    end

    line_act_base = hs_ast ? 1'b0 : line_act;
    nxt_line_act  = line_act_base | de_rise;

    nxt_h_err     = h_err;
    if (de_fall && (x_cnt != H_ACT)) begin
      nxt_h_err = 1'b1;
    end
    if (de_rise && line_act_base) begin
      nxt_h_err = 1'b1;
    end
    if (hs_ast && have_total && (cyc_cnt != line_total)) begin
      nxt_h_err = 1'b1;
    end

    nxt_sum       = de1 ? (sum_acc + pix1) : sum_acc;

    // A frame that ends mid-line still counts that line if it carried pixels.
    act_close     = nxt_act;
    if (nxt_line_act && (nxt_act != LINE_MAX)) begin
      act_close = nxt_act + 10'd1;
    end

    probe_match   = de1 && !probe_done && (x_base == probe_x) && (nxt_act == probe_y);

    good_inc      = (good_cnt >= LOCK_CNT) ? good_cnt : (good_cnt + 8'd1);
  end

  // Frame FSM: line state update, frame snapshot on v_sync, publication and lock tracking a clock later.
  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      state         <= SEARCH;
      cyc_cnt       <= '0;
      line_total    <= '0;
      have_total    <= 1'b0;
      line_cnt      <= '0;
      act_cnt       <= '0;
      line_act      <= 1'b0;
      x_cnt         <= '0;
      h_err         <= 1'b0;
      sum_acc       <= '0;
      probe_done    <= 1'b0;
      good_cnt      <= '0;
      close_pend    <= 1'b0;
      snap_h_total  <= '0;
      snap_v_total  <= '0;
      snap_v_active <= '0;
      snap_sum      <= '0;
      snap_err      <= 1'b0;
      frame_done    <= 1'b0;
      meas_h_total  <= '0;
      meas_v_total  <= '0;
      meas_v_active <= '0;
      frame_sum     <= '0;
      frame_err     <= 1'b0;
      locked        <= 1'b0;
      probe_rgb     <= '0;
      probe_hit     <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      probe_hit  <= 1'b0;
      close_pend <= 1'b0;

      cyc_cnt    <= nxt_cyc;
      line_total <= nxt_total;
      have_total <= nxt_have;
      line_cnt   <= nxt_line_cnt;
      act_cnt    <= nxt_act;
      line_act   <= nxt_line_act;
      x_cnt      <= nxt_x;
      h_err      <= nxt_h_err;
      sum_acc    <= nxt_sum;

      if (probe_match) begin
        probe_rgb  <= pix1;
        probe_hit  <= 1'b1;
        probe_done <= 1'b1;
      end

      if (vs_ast) begin
        // Start of a new frame: per-frame state restarts, line timing carries on.
        line_cnt   <= '0;
        act_cnt    <= '0;
        line_act   <= 1'b0;
        have_total <= 1'b0;
        h_err      <= 1'b0;
        sum_acc    <= '0;
        probe_done <= 1'b0;
        if (state == SEARCH) begin
          state <= ACQUIRE;
        end else begin
          close_pend    <= 1'b1;
          snap_h_total  <= nxt_total;
          snap_v_total  <= nxt_line_cnt;
          snap_v_active <= act_close;
          snap_sum      <= nxt_sum;
          snap_err      <= nxt_h_err | (act_close != V_ACT);
        end
      end

      if (close_pend) begin
        frame_done    <= 1'b1;
        meas_h_total  <= snap_h_total;
        meas_v_total  <= snap_v_total;
        meas_v_active <= snap_v_active;
        frame_sum     <= snap_sum;
        frame_err     <= snap_err;
        if (snap_err) begin
          good_cnt <= '0;
          locked   <= 1'b0;
          state    <= ACQUIRE;
        end else begin
          good_cnt <= good_inc;
          if (good_inc == LOCK_CNT) begin
            locked <= 1'b1;
            state  <= LOCKED;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_lcd_rx_monitor.sv
// Scoreboard bench: an active-low-sync and an active-high-sync monitor watch the same pixel stream.
// Latency: expectations are queued per frame at stimulus time and popped whenever a DUT pulses an output.
// Backpressure: none; stimulus runs on a fixed line/frame raster.
module tb_lcd_rx_monitor;

  typedef struct {
    logic [10:0] h;
    logic [9:0]  vt;
    logic [9:0]  va;
    logic [23:0] sum;
    logic        err;
    logic        lck;
  } frame_exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  r, g, b;
  logic        de;
  logic        hs_lo, vs_lo, hs_hi, vs_hi;
  logic [10:0] probe_x;
  logic [9:0]  probe_y;

  logic        lo_done, lo_err, lo_locked, lo_hit;
  logic [10:0] lo_h;
  logic [9:0]  lo_vt, lo_va;
  logic [23:0] lo_sum, lo_prgb;
  logic        hi_done, hi_err, hi_locked, hi_hit;
  logic [10:0] hi_h;
  logic [9:0]  hi_vt, hi_va;
  logic [23:0] hi_sum, hi_prgb;

  frame_exp_t  q_lo[$];
  frame_exp_t  q_hi[$];
  logic [23:0] pq_lo[$];
  logic [23:0] pq_hi[$];
  frame_exp_t  e_lo, e_hi;

  int tests = 0;
  int fails = 0;
  int good;

  always #5 clk = ~clk;

  lcd_rx_monitor #(.H_ACTIVE(8), .V_ACTIVE(4), .SYNC_ACTIVE_LOW(1), .LOCK_FRAMES(3)) dut_lo (
    .clk_in(clk), .rst(rst), .r(r), .g(g), .b(b), .h_sync(hs_lo), .v_sync(vs_lo), .de(de),
    .probe_x(probe_x), .probe_y(probe_y), .frame_done(lo_done), .meas_h_total(lo_h),
    .meas_v_total(lo_vt), .meas_v_active(lo_va), .frame_sum(lo_sum), .frame_err(lo_err),
    .locked(lo_locked), .probe_rgb(lo_prgb), .probe_hit(lo_hit)
  );

  lcd_rx_monitor #(.H_ACTIVE(8), .V_ACTIVE(4), .SYNC_ACTIVE_LOW(0), .LOCK_FRAMES(3)) dut_hi (
    .clk_in(clk), .rst(rst), .r(r), .g(g), .b(b), .h_sync(hs_hi), .v_sync(vs_hi), .de(de),
    .probe_x(probe_x), .probe_y(probe_y), .frame_done(hi_done), .meas_h_total(hi_h),
    .meas_v_total(hi_vt), .meas_v_active(hi_va), .frame_sum(hi_sum), .frame_err(hi_err),
    .locked(hi_locked), .probe_rgb(hi_prgb), .probe_hit(hi_hit)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic cmp_frame(input string tag, input frame_exp_t e, input logic [10:0] h,
                           input logic [9:0] vt, input logic [9:0] va, input logic [23:0] sum,
                           input logic err, input logic lck);
    check({tag, " meas_h_total"},  32'(h),   32'(e.h));
    check({tag, " meas_v_total"},  32'(vt),  32'(e.vt));
    check({tag, " meas_v_active"}, 32'(va),  32'(e.va));
    check({tag, " frame_sum"},     32'(sum), 32'(e.sum));
    check({tag, " frame_err"},     32'(err), 32'(e.err));
    check({tag, " locked"},        32'(lck), 32'(e.lck));
  endtask

  task automatic check_reset(input string tag);
    check({tag, " lo outputs zero"}, 32'(|{lo_done, lo_h, lo_vt, lo_va, lo_sum, lo_err,
                                           lo_locked, lo_prgb, lo_hit}), 32'd0);
    check({tag, " hi outputs zero"}, 32'(|{hi_done, hi_h, hi_vt, hi_va, hi_sum, hi_err,
                                           hi_locked, hi_prgb, hi_hit}), 32'd0);
  endtask

  // Frame monitor for the active-low instance.
  always @(negedge clk) begin
    if (lo_done) begin
      if (q_lo.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL lo frame_done: pulse seen, no frame expected");
      end else begin
        e_lo = q_lo.pop_front();
        cmp_frame("lo", e_lo, lo_h, lo_vt, lo_va, lo_sum, lo_err, lo_locked);
      end
    end
    if (lo_hit) begin
      if (pq_lo.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL lo probe_hit: pulse seen, no hit expected");
      end else begin
        check("lo probe_rgb", 32'(lo_prgb), 32'(pq_lo.pop_front()));
      end
    end
  end

  // Frame monitor for the active-high instance.
  always @(negedge clk) begin
    if (hi_done) begin
      if (q_hi.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL hi frame_done: pulse seen, no frame expected");
      end else begin
        e_hi = q_hi.pop_front();
        cmp_frame("hi", e_hi, hi_h, hi_vt, hi_va, hi_sum, hi_err, hi_locked);
      end
    end
    if (hi_hit) begin
      if (pq_hi.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL hi probe_hit: pulse seen, no hit expected");
      end else begin
        check("hi probe_rgb", 32'(hi_prgb), 32'(pq_hi.pop_front()));
      end
    end
  end

  // One pixel clock: syncs given as asserted flags, translated to each instance's polarity.
  task automatic drive_cycle(input bit hs_a, input bit vsl_a, input bit vsh_a, input bit de_v,
                             input logic [23:0] pix);
    @(posedge clk);
    #1;
    hs_lo = ~hs_a;
    vs_lo = ~vsl_a;
    hs_hi = hs_a;
    vs_hi = vsh_a;
    de    = de_v;
    {r, g, b} = de_v ? pix : 24'h0;
  endtask

  // 6 lines x 12 clocks, h_sync at cycles 0-1, de at cycles 2-9 on lines 1-4.
  // Active-low v_sync asserts at cycle 5 of line 0; active-high v_sync together with h_sync at cycle 0.
  // mode 0: {1,1,1}; mode 1: running pixel index; mode 2: all ones.
  task automatic run_frame(input int mode, input bit bad, input bit rst_mid,
                           input logic [23:0] exp_sum, input logic [23:0] exp_probe);
    frame_exp_t  e;
    int          p;
    bit          dv;
    logic [23:0] pix;
    p = 0;
    if (rst_mid) begin
      good = 0;
    end else begin
      if (bad) good = 0;
      else if (good < 3) good++;
      e.h   = 11'd12;
      e.vt  = 10'd6;
      e.va  = 10'd4;
      e.sum = exp_sum;
      e.err = bad;
      e.lck = (good == 3);
      q_lo.push_back(e);
      q_hi.push_back(e);
    end
    pq_lo.push_back(exp_probe);
    pq_hi.push_back(exp_probe);
    for (int l = 0; l < 6; l++) begin
      for (int c = 0; c < 12; c++) begin
        dv = (l >= 1) && (l <= 4) && (c >= 2) && (c <= (((bad != 0) && (l == 4)) ? 8 : 9));
        case (mode)
          1:       pix = 24'(p);
          2:       pix = 24'hFFFFFF;
          default: pix = 24'h010101;
        endcase
        drive_cycle(c < 2, (l == 0) && (c == 5 || c == 6), (l == 0) && (c <= 3), dv, pix);
        if (dv) p++;
        if (rst_mid && l == 5 && c == 5) begin
          rst = 1'b0;
          #1;
          check_reset("mid-frame reset");
        end
        if (rst_mid && l == 5 && c == 8) rst = 1'b1;
      end
    end
  endtask

  initial begin
    rst     = 1'b0;
    hs_lo   = 1'b1;
    vs_lo   = 1'b1;
    hs_hi   = 1'b0;
    vs_hi   = 1'b0;
    de      = 1'b0;
    r       = 8'h0;
    g       = 8'h0;
    b       = 8'h0;
    probe_x = 11'd3;
    probe_y = 10'd2;
    good    = 0;

    repeat (3) @(posedge clk);
    #1;
    check_reset("power-on reset");
    rst = 1'b1;
    repeat (4) drive_cycle(0, 0, 0, 0, 24'h0);

    // Clean frames until lock, reported from the second v_sync onwards.
    repeat (4) run_frame(0, 0, 0, 24'h202020, 24'h010101);
    // One short line: error, lock lost, three clean frames to relock.
    run_frame(0, 1, 0, 24'h1F1F1F, 24'h010101);
    repeat (3) run_frame(0, 0, 0, 24'h202020, 24'h010101);
    // Incrementing pixels: probe at row 2, column 3 reads 19; sum 0..31 = 496.
    run_frame(1, 0, 0, 24'h0001F0, 24'h000013);
    // All-ones pixels: checksum wraps to 0xFFFFE0.
    run_frame(2, 0, 0, 24'hFFFFE0, 24'hFFFFFF);
    // Reset in the blanking line discards this frame; the next v_sync only re-acquires.
    run_frame(0, 0, 1, 24'h0, 24'h010101);
    run_frame(1, 0, 0, 24'h0001F0, 24'h000013);
    run_frame(0, 0, 0, 24'h202020, 24'h010101);

    // Closing v_sync for the last frame, then drain.
    for (int c = 0; c < 12; c++) begin
      drive_cycle(c < 2, (c == 5 || c == 6), (c <= 3), 0, 24'h0);
    end
    repeat (20) drive_cycle(0, 0, 0, 0, 24'h0);

    check("lo frames outstanding", 32'(q_lo.size()),  32'd0);
    check("hi frames outstanding", 32'(q_hi.size()),  32'd0);
    check("lo probes outstanding", 32'(pq_lo.size()), 32'd0);
    check("hi probes outstanding", 32'(pq_hi.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
